// File: rtl/uart_command_serializer_pkg.sv
// Shared constants and state encoding for the UART/BLE command path.
// Terminator bytes are common with the receive-side accumulator.
package uart_command_serializer_pkg;

  localparam logic [7:0] UART_TERM_0 = 8'hBE;
  localparam logic [7:0] UART_TERM_1 = 8'hEF;
  localparam logic [7:0] BLE_TERM    = 8'h0D;

  localparam int MAX_CMD_BYTES = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAYLOAD,
    S_TERM,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/uart_command_serializer_timeout_counter.sv
// Stall counter for the UART transmit handshake.
// expired fires on the enabled cycle whose increment would reach TIMEOUT.
module uart_tx_timeout_counter #(
  parameter int TIMEOUT = 1026
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        expired = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_command_serializer.sv
// Streams a latched command buffer byte-by-byte to the UART transmitter.
// Define UART_CMD_SERIALIZER_TERM_EN to append the UART/BLE terminator.
module uart_command_serializer
  import uart_command_serializer_pkg::*;
#(
  parameter int MAX_BYTES = MAX_CMD_BYTES,
  parameter int TIMEOUT   = 1026
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [MAX_BYTES*8-1:0] input_data,
  input  logic [7:0]             input_data_size,
  input  logic                   start,
  input  logic                   ble_side,
  input  logic                   tx_ready,
  output logic [7:0]             output_data,
  output logic                   output_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int IW = $clog2(MAX_BYTES);

  state_e               state_q, state_d;
  logic [MAX_BYTES*8-1:0] buf_q, buf_d;
  logic [7:0]           size_q, size_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 error_q, error_d;
  logic                 pending;
  logic                 tmo_en;
  logic                 tmo_expired;
  logic [7:0]           cur_byte;

`ifdef UART_CMD_SERIALIZER_TERM_EN
  logic                 ble_q, ble_d;
  logic                 term_q, term_d;
  logic [7:0]           term_byte;

  assign term_byte = ble_q  ? BLE_TERM :
                     term_q ? UART_TERM_1 : UART_TERM_0;
`else
  logic                 unused_ble;

  assign unused_ble = ble_side;
`endif

  // A byte is offered in both payload and terminator phases.
  assign pending  = (state_q == S_PAYLOAD) || (state_q == S_TERM);
  assign tmo_en   = pending & ~tx_ready;
  assign cur_byte = buf_q[{idx_q, 3'b000} +: 8];

  uart_tx_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clear   (~tmo_en),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    size_d       = size_q;
    idx_d        = idx_q;
    error_d      = error_q;
`ifdef UART_CMD_SERIALIZER_TERM_EN
    ble_d        = ble_q;
    term_d       = term_q;
`endif
    output_valid = pending;
    output_data  = 8'h00;
    busy         = pending;
    done         = 1'b0;
    error        = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          buf_d   = input_data;
          size_d  = input_data_size;
          idx_d   = '0;
          error_d = 1'b0;
`ifdef UART_CMD_SERIALIZER_TERM_EN
          ble_d   = ble_side;
          term_d  = 1'b0;
`endif
          if (input_data_size == 8'd0 ||
              input_data_size > MAX_BYTES) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        output_data = cur_byte;
        if (tx_ready) begin
          if (idx_q == IW'(size_q - 8'd1)) begin
`ifdef UART_CMD_SERIALIZER_TERM_EN
            state_d = S_TERM;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_CMD_SERIALIZER_TERM_EN
      S_TERM: begin
        output_data = term_byte;
        if (tx_ready) begin
          if (ble_q || term_q) state_d = S_DONE;
          else                 term_d  = 1'b1;
        end
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A stalled byte is abandoned, not retried.
    if (tmo_expired) begin
      state_d = S_ERROR;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      size_q  <= '0;
      idx_q   <= '0;
      error_q <= 1'b0;
`ifdef UART_CMD_SERIALIZER_TERM_EN
      ble_q   <= 1'b0;
      term_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      error_q <= error_d;
`ifdef UART_CMD_SERIALIZER_TERM_EN
      ble_q   <= ble_d;
      term_q  <= term_d;
`endif
    end
  end

endmodule

// File: doc/uart_command_serializer.md
Name: uart_command_serializer

Overview:
- Transmit-side counterpart of the UART/BLE command accumulator.
- Takes a fully formed command buffer (up to 128 bytes, packed little-endian into 1024 bits) plus a byte count, and streams it one byte at a time to the UART transmitter over a valid/ready handshake.
- Appends the link terminator: 0xBE 0xEF on the UART side, 0x0D on the BLE side.
- Signals done on completion. Signals error on a bad size or a stalled transmitter.

Parameters:
- MAX_BYTES, 128, maximum payload bytes; buffer width is MAX_BYTES*8.
- TIMEOUT, 1026, clock cycles tx_ready may stay low while a byte is pending before error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- input_data  input  1024  command payload; byte k occupies bits [8k+7:8k].
- input_data_size  input  8  payload byte count, valid range 1..128.
- start  input  1  request to send; sampled only in IDLE.
- ble_side  input  1  terminator select, sampled at start: 0 = 0xBE 0xEF, 1 = 0x0D.
- tx_ready  input  1  UART transmitter can accept a byte this cycle.
- output_data  output  8  byte presented to the transmitter.
- output_valid  output  1  output_data is valid; a transfer occurs when output_valid & tx_ready at a rising edge.
- busy  output  1  high from the cycle after start is accepted until DONE/ERROR.
- done  output  1  one-cycle pulse after the last terminator byte transfers.
- error  output  1  sticky error flag.

Behaviour:
- Reset values: output_data=0, output_valid=0, busy=0, done=0, error=0. Internal buffer, byte index and timeout counter are cleared and the FSM goes to IDLE.
- Reset mid-operation aborts immediately. No partial terminator is sent.
- FSM states:
  - IDLE:
    - On start=1, latch input_data, input_data_size and ble_side, and clear error.
    - If size==0 or size>MAX_BYTES, go to ERROR.
    - Otherwise go to PAYLOAD with index=0.
  - PAYLOAD:
    - output_valid=1, output_data = byte[index]; the first byte is valid the cycle after start (latency 1).
    - On transfer: if index==size-1, go to TERM with term_idx=0; else index++.
    - output_data is held stable while tx_ready=0.
  - TERM:
    - UART side: sends 0xBE then 0xEF.
    - BLE side: sends 0x0D only.
    - After the last terminator byte transfers, go to DONE.
  - DONE: done=1 and output_valid=0 for exactly one cycle, then IDLE.
  - ERROR: error=1, output_valid=0, then IDLE. error stays high until the next accepted start or reset.
- Timeout:
  - The counter increments every cycle output_valid=1 and tx_ready=0, and clears on each transfer.
  - Reaching TIMEOUT goes to ERROR; the pending byte is dropped.
- start while busy is ignored; input changes while busy are ignored because inputs are latched.
- start asserted in the DONE cycle is ignored; start is accepted again one cycle later, in IDLE.
- With tx_ready held high, each byte takes one cycle. Total busy cycles = size + terminator length (2 UART, 1 BLE).
- Byte index is 7 bits; size 128 reaches index 127 with no wrap.

Optional Feature:
- Macro: UART_CMD_SERIALIZER_TERM_EN.
- Defined: the terminator is appended as above, selected by ble_side.
- Undefined: TERM is skipped; DONE follows the last payload byte directly. ble_side is unused but the port is still present.

Decomposition:
- Shared package holds:
  - UART_TERM_0=8'hBE, UART_TERM_1=8'hEF, BLE_TERM=8'h0D (shared with the accumulator).
  - MAX_CMD_BYTES=128.
  - The state enumeration localparams.
- Natural sub-module: uart_tx_timeout_counter. It is a TIMEOUT-wide counter with clear/enable and an expired flag, and can be reused by the accumulator.
- The remaining logic is a single FSM module.

Test Plan:
- UART side, size=10, bytes 0x27, tx_ready=1 → ten 0x27 transfers on consecutive cycles, then 0xBE, 0xEF; done pulses once 13 cycles after start; error=0.
- BLE side, size=3, bytes 0x01..0x03, tx_ready toggling every other cycle → sequence 01,02,03,0D with output_data held stable during stalls; done pulses once.
- Size=128, bytes 0x01..0x80, tx_ready=1 → 128 bytes in order, then BE, EF; index does not wrap; done pulses.
- Size=0 and size=129 → error=1 the cycle after start, no output_valid, busy stays 0; a following valid start clears error.
- Size=5 with tx_ready forced low after the 2nd byte → error asserts 1026 cycles after output_valid of the 3rd byte; no further bytes are sent.
- Reset pulse during the 4th payload byte → all outputs are 0 immediately; a new start with size=2 sends 2 bytes plus terminator cleanly.
